mul_sweep_driver: RTL and testbench

- Driver and checker for the multiplier interface: supplies operand pairs to a combinational WIDTH×WIDTH multiplier and samples its product and overflow.
- Runs one exhaustive sweep of all 2^(2·WIDTH) operand pairs, one pair per clock.
- Compares each product against an internally computed exact product and accumulates error metrics for characterising approximate Dadda variants.
- Sits next to a multiplier instance in characterisation and FPGA-in-the-loop builds.

---
 rtl/mul_sweep_driver.sv | 128 ++++++++++++
 tb/tb_mul_sweep_driver.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/mul_sweep_driver.sv
// Exhaustive operand sweep driver/checker for a combinational WIDTH x WIDTH multiplier.
// Optional worst-pair capture ports are enabled by defining WORST_CASE_CAPTURE_EN.
module mul_sweep_driver #(
  parameter int unsigned WIDTH = 6
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_start,
  input  logic                 i_abort,
  output logic [WIDTH-1:0]     o_mul_in1,
  output logic [WIDTH-1:0]     o_mul_in2,
  input  logic [2*WIDTH-1:0]   i_mul_out,
  input  logic                 i_mul_overflow,
  output logic                 o_busy,
  output logic                 o_done,
  output logic [2*WIDTH:0]     o_err_count,
  output logic [4*WIDTH-1:0]   o_sum_abs_err,
  output logic [2*WIDTH-1:0]   o_max_err,
`ifdef WORST_CASE_CAPTURE_EN
  output logic [WIDTH-1:0]     o_worst_in1,
  output logic [WIDTH-1:0]     o_worst_in2,
  output logic [2*WIDTH-1:0]   o_worst_out,
`endif
  output logic                 o_ovf_seen
);

  localparam int unsigned PW = 2 * WIDTH;

  typedef enum logic [1:0] {
    StIdle,
    StSweep,
    StDone
  } state_e;

  state_e          r_state;
  logic [PW-1:0]   r_idx;
  logic [PW-1:0]   w_exact;
  logic [PW-1:0]   w_abs_err;
  logic            w_err;
  logic            w_new_max;

  assign o_mul_in1 = r_idx[PW-1:WIDTH];
  assign o_mul_in2 = r_idx[WIDTH-1:0];

  // Subtraction ordered by magnitude, so the PW-bit result is always the true |difference|.
  assign w_exact   = PW'(o_mul_in1) * PW'(o_mul_in2);
  assign w_abs_err = (i_mul_out < w_exact) ? (w_exact - i_mul_out) : (i_mul_out - w_exact);
  assign w_err     = (w_abs_err != '0);
  assign w_new_max = (w_abs_err > o_max_err);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state       <= StIdle;
      r_idx         <= '0;
      o_busy        <= 1'b0;
      o_done        <= 1'b0;
      o_err_count   <= '0;
      o_sum_abs_err <= '0;
      o_max_err     <= '0;
      o_ovf_seen    <= 1'b0;
`ifdef WORST_CASE_CAPTURE_EN
      o_worst_in1   <= '0;
      o_worst_in2   <= '0;
      o_worst_out   <= '0;
`endif
    end else begin
      unique case (r_state)
        StIdle, StDone: begin
          if (i_abort) begin
            r_state <= StIdle;
            o_busy  <= 1'b0;
            o_done  <= 1'b0;
          end else if (i_start) begin
            r_state       <= StSweep;
            r_idx         <= '0;
            o_busy        <= 1'b1;
            o_done        <= 1'b0;
            o_err_count   <= '0;
            o_sum_abs_err <= '0;
            o_max_err     <= '0;
            o_ovf_seen    <= 1'b0;
`ifdef WORST_CASE_CAPTURE_EN
            o_worst_in1   <= '0;
            o_worst_in2   <= '0;
            o_worst_out   <= '0;
`endif
          end
        end

        StSweep: begin
          // The pair on the ports is always accounted for, even on an aborting edge.
          if (w_err) begin
            o_err_count <= o_err_count + (PW + 1)'(1);
          end
          o_sum_abs_err <= o_sum_abs_err + (4 * WIDTH)'(w_abs_err);
          if (w_new_max) begin
            o_max_err <= w_abs_err;
`ifdef WORST_CASE_CAPTURE_EN
            o_worst_in1 <= o_mul_in1;
            o_worst_in2 <= o_mul_in2;
            o_worst_out <= i_mul_out;
`endif
          end
          o_ovf_seen <= o_ovf_seen | i_mul_overflow;

          if (i_abort) begin
            r_state <= StIdle;
            o_busy  <= 1'b0;
            o_done  <= 1'b0;
          end else if (r_idx == '1) begin
            r_state <= StDone;
            o_busy  <= 1'b0;
            o_done  <= 1'b1;
          end else begin
            r_idx <= r_idx + PW'(1);
          end
        end

        default: begin
          r_state <= StIdle;
          o_busy  <= 1'b0;
          o_done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mul_sweep_driver.sv
// Bench for mul_sweep_driver: table of full sweeps against multiplier stubs plus abort,
// start-ignore, restart and reset sequences. Worst-pair checks need WORST_CASE_CAPTURE_EN.
module tb_mul_sweep_driver;

  localparam int unsigned WIDTH = 6;

  logic               clk;
  logic               rst_n;
  logic               i_start;
  logic               i_abort;
  logic [WIDTH-1:0]   mul_in1;
  logic [WIDTH-1:0]   mul_in2;
  logic [2*WIDTH-1:0] mul_out;
  logic               mul_overflow;
  logic               busy;
  logic               done;
  logic [2*WIDTH:0]   err_count;
  logic [4*WIDTH-1:0] sum_abs_err;
  logic [2*WIDTH-1:0] max_err;
  logic               ovf_seen;
`ifdef WORST_CASE_CAPTURE_EN
  logic [WIDTH-1:0]   worst_in1;
  logic [WIDTH-1:0]   worst_in2;
  logic [2*WIDTH-1:0] worst_out;
`endif

  int mode;
  int n_total;
  int n_bad;

  mul_sweep_driver #(
    .WIDTH (WIDTH)
  ) u_dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_start        (i_start),
    .i_abort        (i_abort),
    .o_mul_in1      (mul_in1),
    .o_mul_in2      (mul_in2),
    .i_mul_out      (mul_out),
    .i_mul_overflow (mul_overflow),
    .o_busy         (busy),
    .o_done         (done),
    .o_err_count    (err_count),
    .o_sum_abs_err  (sum_abs_err),
    .o_max_err      (max_err),
`ifdef WORST_CASE_CAPTURE_EN
    .o_worst_in1    (worst_in1),
    .o_worst_in2    (worst_in2),
    .o_worst_out    (worst_out),
`endif
    .o_ovf_seen     (ovf_seen)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Multiplier stubs: 0 exact, 1 bit0 forced low, 2 exact+5 at (63,63), 3 overflow at idx 2000.
  logic [2*WIDTH-1:0] stub_exact;
  always_comb begin
    stub_exact   = {6'd0, mul_in1} * {6'd0, mul_in2};
    mul_out      = stub_exact;
    mul_overflow = 1'b0;
    case (mode)
      1: mul_out[0] = 1'b0;
      2: if (mul_in1 == 6'd63 && mul_in2 == 6'd63) mul_out = stub_exact + 12'd5;
      3: if ({mul_in1, mul_in2} == 12'd2000) mul_overflow = 1'b1;
      default: ;
    endcase
  end

  typedef struct {
    string name;
    int    mode;
    int    err;
    int    sum;
    int    mx;
    int    ovf;
    int    w1;
    int    w2;
    int    wo;
  } vec_t;

  vec_t vecs[4];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int unsigned act, input int unsigned exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Pulses start, then counts edges until done; optional re-pulse of start mid-sweep.
  task automatic run_sweep(input int repulse_at, output int cycles);
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    check("busy_after_start", busy, 1);
    cycles = 0;
    while (!done && cycles < 5000) begin
      i_start = (cycles == repulse_at);
      tick();
      cycles++;
    end
    i_start = 1'b0;
  endtask

  initial begin
    int cyc;
    n_total = 0;
    n_bad   = 0;
    mode    = 0;
    i_start = 1'b0;
    i_abort = 1'b0;
    rst_n   = 1'b0;

    vecs[0] = '{"exact", 0, 0,    0,    0, 0, 0,  0,  0};
    vecs[1] = '{"bit0",  1, 1024, 1024, 1, 0, 1,  1,  0};
    vecs[2] = '{"plus5", 2, 1,    5,    5, 0, 63, 63, 3974};
    vecs[3] = '{"ovf",   3, 0,    0,    0, 1, 0,  0,  0};

    repeat (3) tick();
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_in1", mul_in1, 0);
    check("rst_in2", mul_in2, 0);
    check("rst_err", err_count, 0);
    check("rst_ovf", ovf_seen, 0);
    rst_n = 1'b1;
    tick();
    check("idle_hold_busy", busy, 0);

    for (int v = 0; v < 4; v++) begin
      mode = vecs[v].mode;
      run_sweep(-1, cyc);
      check({vecs[v].name, "_cycles"}, cyc, 4096);
      check({vecs[v].name, "_done"}, done, 1);
      check({vecs[v].name, "_busy"}, busy, 0);
      check({vecs[v].name, "_err"}, err_count, vecs[v].err);
      check({vecs[v].name, "_sum"}, sum_abs_err, vecs[v].sum);
      check({vecs[v].name, "_max"}, max_err, vecs[v].mx);
      check({vecs[v].name, "_ovf"}, ovf_seen, vecs[v].ovf);
      check({vecs[v].name, "_in1_hold"}, mul_in1, 63);
      check({vecs[v].name, "_in2_hold"}, mul_in2, 63);
`ifdef WORST_CASE_CAPTURE_EN
      check({vecs[v].name, "_worst_in1"}, worst_in1, vecs[v].w1);
      check({vecs[v].name, "_worst_in2"}, worst_in2, vecs[v].w2);
      check({vecs[v].name, "_worst_out"}, worst_out, vecs[v].wo);
`endif
      tick();
      check({vecs[v].name, "_done_hold"}, done, 1);
    end

    // Abort on the 100th sweep edge: pairs 0..99 evaluated, idx held at 99.
    mode    = 1;
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    repeat (99) tick();
    i_abort = 1'b1;
    tick();
    i_abort = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_err", err_count, 18);
    check("abort_sum", sum_abs_err, 18);
    check("abort_max", max_err, 1);
    repeat (2) tick();
    check("abort_hold_err", err_count, 18);
    check("abort_hold_in1", mul_in1, 1);
    check("abort_hold_in2", mul_in2, 35);

    // Abort beats start.
    i_start = 1'b1;
    i_abort = 1'b1;
    tick();
    i_start = 1'b0;
    i_abort = 1'b0;
    check("abort_wins_busy", busy, 0);
    check("abort_wins_err", err_count, 18);

    // Start re-pulsed mid-sweep is ignored.
    run_sweep(50, cyc);
    check("repulse_cycles", cyc, 4096);
    check("repulse_done", done, 1);
    check("repulse_err", err_count, 1024);
    check("repulse_sum", sum_abs_err, 1024);

    // Start from DONE clears statistics and restarts at pair 0.
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    check("restart_busy", busy, 1);
    check("restart_done", done, 0);
    check("restart_err", err_count, 0);
    check("restart_sum", sum_abs_err, 0);
    check("restart_in1", mul_in1, 0);
    check("restart_in2", mul_in2, 0);
    i_abort = 1'b1;
    tick();
    i_abort = 1'b0;

    // Async reset mid-sweep after the overflow pair has been seen.
    mode    = 3;
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    repeat (3000) tick();
    check("pre_rst_ovf", ovf_seen, 1);
    check("pre_rst_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    check("midrst_busy", busy, 0);
    check("midrst_ovf", ovf_seen, 0);
    check("midrst_in1", mul_in1, 0);
    check("midrst_in2", mul_in2, 0);
    check("midrst_max", max_err, 0);
    tick();
    rst_n = 1'b1;
    repeat (2) tick();
    check("post_rst_idle", busy, 0);
    check("post_rst_in2", mul_in2, 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
